hazard_controller: RTL and testbench

Pipeline hazard and stall controller for the five-stage MIPS datapath; the counterpart to the forwarding unit. Forwarding resolves data hazards it can bypass. This block handles the hazards it cannot:

- load-use dependencies,
- instruction- and data-memory waits,
- branch and jump redirection,
- halt.

It drives the enable and flush inputs of the four pipeline latches and the PC. It also keeps a saturating stall-cycle counter.

---
 rtl/hazard_controller.sv | 131 +++++++++++++
 tb/tb_hazard_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Stall/flush controller for the five-stage pipeline: handles load-use, memory waits,
// branch/jump redirection and halt; keeps a saturating count of RUN cycles with the PC held.
module hazard_controller #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dREN,
   input  logic             mem_dWEN,
   input  logic             mem_branch_taken,
   input  logic             mem_halt,
   input  logic             dec_jump,
   input  logic [4:0]       dec_rs,
   input  logic [4:0]       dec_rt,
   input  logic             dec_uses_rt,
   input  logic             ex_mem_to_reg,
   input  logic [4:0]       ex_reg_wr_addr,
   output logic             pc_en,
   output logic             fd_en,
   output logic             de_en,
   output logic             em_en,
   output logic             mw_en,
   output logic             fd_flush,
   output logic             de_flush,
   output logic             em_flush,
   output logic             halt_out,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic             halt_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic dreq_s, dstall_s, load_use_s;

   assign dreq_s     = mem_dREN | mem_dWEN;
   assign dstall_s   = dreq_s & ~dhit;
   // r0 is never a real destination, so a load to r0 cannot create a dependency
   assign load_use_s = ex_mem_to_reg & (ex_reg_wr_addr != 5'd0) &
                       ((ex_reg_wr_addr == dec_rs) | (dec_uses_rt & (ex_reg_wr_addr == dec_rt)));

   // Next state and pipeline enables/flushes
   always_comb begin
      state_d  = state_q;
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_en    = 1'b0;
      em_en    = 1'b0;
      mw_en    = 1'b0;
      fd_flush = 1'b0;
      de_flush = 1'b0;
      em_flush = 1'b0;
      if (RST) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (dstall_s) begin
                  state_d = RUN;
               end else if (~ihit & dreq_s) begin
                  mw_en    = 1'b1;
                  em_en    = 1'b1;
                  em_flush = 1'b1;
               end else if (~ihit) begin
                  state_d = RUN;
               end else begin
                  if (mem_branch_taken) begin
                     {pc_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
                     {fd_flush, de_flush, em_flush}      = 3'b111;
                  end else if (load_use_s) begin
                     de_en    = 1'b1;
                     de_flush = 1'b1;
                     em_en    = 1'b1;
                     mw_en    = 1'b1;
                  end else if (dec_jump) begin
                     {pc_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
                     fd_flush = 1'b1;
                  end else begin
                     {pc_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
                  end
                  if (mem_halt) begin
                     state_d = HALT;
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
         endcase
      end
   end

   // Stall counter next value: saturates instead of wrapping
   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == RUN) && !pc_en && !RST) begin
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State, halt flag and stall counter registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= RUN;
         halt_q  <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         halt_q  <= (state_d == HALT);
         cnt_q   <= cnt_d;
      end
   end

   assign halt_out    = halt_q;
   assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller; a 4-bit-counter instance shares the inputs for saturation.
module tb_hazard_controller;

   logic       CLK, RST;
   logic       ihit, dhit, mem_dREN, mem_dWEN, mem_branch_taken, mem_halt, dec_jump;
   logic [4:0] dec_rs, dec_rt, ex_reg_wr_addr;
   logic       dec_uses_rt, ex_mem_to_reg;

   logic        pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush, halt_out;
   logic [31:0] stall_count;
   logic        pc_en4, fd_en4, de_en4, em_en4, mw_en4, fd_flush4, de_flush4, em_flush4, halt_out4;
   logic [3:0]  stall_count4;
   logic [7:0]  ctl_s;

   int total_q = 0;
   int bad_q   = 0;

   assign ctl_s = {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush};

   hazard_controller #(.CNT_W(32)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
      .mem_branch_taken(mem_branch_taken), .mem_halt(mem_halt), .dec_jump(dec_jump),
      .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rt(dec_uses_rt), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_reg_wr_addr(ex_reg_wr_addr), .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en),
      .mw_en(mw_en), .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush),
      .halt_out(halt_out), .stall_count(stall_count));

   hazard_controller #(.CNT_W(4)) dut4 (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
      .mem_branch_taken(mem_branch_taken), .mem_halt(mem_halt), .dec_jump(dec_jump),
      .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rt(dec_uses_rt), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_reg_wr_addr(ex_reg_wr_addr), .pc_en(pc_en4), .fd_en(fd_en4), .de_en(de_en4), .em_en(em_en4),
      .mw_en(mw_en4), .fd_flush(fd_flush4), .de_flush(de_flush4), .em_flush(em_flush4),
      .halt_out(halt_out4), .stall_count(stall_count4));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_q++;
      if (obs !== exp) begin
         bad_q++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      ihit = 1'b0; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
      mem_branch_taken = 1'b0; mem_halt = 1'b0; dec_jump = 1'b0;
      dec_rs = 5'd0; dec_rt = 5'd0; dec_uses_rt = 1'b0;
      ex_mem_to_reg = 1'b0; ex_reg_wr_addr = 5'd0;
   endtask

   // go to the next falling edge (inputs change here, comb outputs settle 1 ns later)
   task automatic fall();
      @(negedge CLK);
   endtask

   task automatic rise();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      fall();
      RST = 1'b1;
      idle_inputs();
      fall();
      RST = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      idle_inputs();
      ihit = 1'b1;
      #2;
      chk("rst_ctl", {24'd0, ctl_s}, 32'h00);
      chk("rst_halt", {31'd0, halt_out}, 32'd0);
      chk("rst_cnt", stall_count, 32'd0);
      fall();
      RST = 1'b0;

      // load-use on rs
      ex_mem_to_reg = 1'b1; ex_reg_wr_addr = 5'd5; dec_rs = 5'd5; ihit = 1'b1;
      #1 chk("lu_ctl", {24'd0, ctl_s}, 32'h3A);
      rise(); chk("lu_cnt", stall_count, 32'd1);
      // destination r0: no dependency
      fall(); ex_reg_wr_addr = 5'd0; dec_rs = 5'd0;
      #1 chk("lu_r0_ctl", {24'd0, ctl_s}, 32'hF8);
      rise(); chk("lu_r0_cnt", stall_count, 32'd1);
      // load-use on rt
      fall(); ex_reg_wr_addr = 5'd7; dec_rs = 5'd3; dec_rt = 5'd7; dec_uses_rt = 1'b1;
      #1 chk("lu_rt_ctl", {24'd0, ctl_s}, 32'h3A);
      rise(); chk("lu_rt_cnt", stall_count, 32'd2);
      // rt matches but is not read
      fall(); dec_uses_rt = 1'b0;
      #1 chk("lu_rt_unused", {24'd0, ctl_s}, 32'hF8);

      // data wait then back-end retire
      do_reset();
      mem_dREN = 1'b1; dhit = 1'b0; ihit = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("dwait_ctl", {24'd0, ctl_s}, 32'h00);
         fall();
      end
      dhit = 1'b1; ihit = 1'b0;
      #1 chk("backend_ctl", {24'd0, ctl_s}, 32'h19);
      rise(); chk("dwait_cnt", stall_count, 32'd4);
      fall(); ihit = 1'b1; mem_dREN = 1'b0; mem_dWEN = 1'b1;
      #1 chk("store_adv_ctl", {24'd0, ctl_s}, 32'hF8);
      rise(); chk("store_adv_cnt", stall_count, 32'd4);
      fall(); mem_dWEN = 1'b0; ihit = 1'b0;
      #1 chk("idle_ctl", {24'd0, ctl_s}, 32'h00);
      rise(); chk("idle_cnt", stall_count, 32'd5);

      // branch beats load-use and jump
      fall(); idle_inputs();
      ihit = 1'b1; mem_branch_taken = 1'b1; dec_jump = 1'b1;
      ex_mem_to_reg = 1'b1; ex_reg_wr_addr = 5'd9; dec_rs = 5'd9;
      #1 chk("br_ctl", {24'd0, ctl_s}, 32'hFF);
      rise(); chk("br_cnt", stall_count, 32'd5);
      // jump alone
      fall(); idle_inputs(); ihit = 1'b1; dec_jump = 1'b1;
      #1 chk("jmp_ctl", {24'd0, ctl_s}, 32'hFC);
      // load-use beats jump
      fall(); ex_mem_to_reg = 1'b1; ex_reg_wr_addr = 5'd4; dec_rs = 5'd4;
      #1 chk("lu_jmp_ctl", {24'd0, ctl_s}, 32'h3A);
      rise(); chk("lu_jmp_cnt", stall_count, 32'd6);

      // halt
      fall(); idle_inputs(); ihit = 1'b1; mem_halt = 1'b1;
      #1 chk("halt_ctl", {24'd0, ctl_s}, 32'hF8);
      chk("halt_pre", {31'd0, halt_out}, 32'd0);
      rise(); chk("halt_out", {31'd0, halt_out}, 32'd1);
      fall(); mem_halt = 1'b0; ihit = 1'b1; dhit = 1'b1; mem_dREN = 1'b1;
      #1 chk("halted_ctl", {24'd0, ctl_s}, 32'h00);
      fall(); ihit = 1'b0; mem_dREN = 1'b0;
      #1 chk("halted_ctl2", {24'd0, ctl_s}, 32'h00);
      rise(); chk("halted_cnt", stall_count, 32'd6);
      chk("halted_stay", {31'd0, halt_out}, 32'd1);
      // asynchronous reset mid-HALT
      fall(); #2 RST = 1'b1;
      #1 chk("arst_halt", {31'd0, halt_out}, 32'd0);
      chk("arst_cnt", stall_count, 32'd0);
      fall(); RST = 1'b0; ihit = 1'b1;
      #1 chk("post_rst_ctl", {24'd0, ctl_s}, 32'hF8);
      rise(); chk("post_rst_halt", {31'd0, halt_out}, 32'd0);

      // branch together with halt: flush and halt
      fall(); mem_branch_taken = 1'b1; mem_halt = 1'b1;
      #1 chk("brhalt_ctl", {24'd0, ctl_s}, 32'hFF);
      rise(); chk("brhalt_out", {31'd0, halt_out}, 32'd1);

      // saturation on the 4-bit instance
      do_reset();
      for (int i = 0; i < 15; i++) rise();
      chk("sat_15", {28'd0, stall_count4}, 32'd15);
      for (int i = 0; i < 5; i++) rise();
      chk("sat_hold", {28'd0, stall_count4}, 32'd15);
      chk("wide_20", stall_count, 32'd20);

      $display("test done: total=%0d bad=%0d", total_q, bad_q);
      $finish;
   end

endmodule
